// File: rtl/game_timer.sv
// ----------------------------------------------------------------------------
// game_timer
//   Game stopwatch with count-up / count-down modes, pause, a fixed time
//   limit and a time-up flag. A prescaler divides clk down to hundredths of
//   a second; the value is kept as {seconds, hundredths}.
//
// Parameters
//   CLK_FREQ_HZ  clk frequency; DIV = CLK_FREQ_HZ/100 cycles per hundredth
//   LIMIT_SEC    time limit in whole seconds (1 <= LIMIT_SEC < 2**SEC_W)
//   SEC_W        width of the seconds output
//   COUNT_DOWN   0: 0.00 -> LIMIT_SEC.00, 1: LIMIT_SEC.00 -> 0.00
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous, active-high reset
//   start           in   1-cycle pulse: reload the initial value and run
//   pause           in   level: freeze counting while high
//   stop            in   1-cycle pulse: halt and hold the current value
//   running         out  high in RUN
//   time_up         out  high in EXPIRED
//   tick_hundredth  out  1-cycle pulse aligned with each value update
//   seconds         out  current seconds
//   hundredths      out  current hundredths (0..99)
// ----------------------------------------------------------------------------
module game_timer #(
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int LIMIT_SEC   = 60,
    parameter int SEC_W       = 6,
    parameter int COUNT_DOWN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             running,
    output logic             time_up,
    output logic             tick_hundredth,
    output logic [SEC_W-1:0] seconds,
    output logic [6:0]       hundredths
);

    localparam int DIV   = CLK_FREQ_HZ / 100;
    localparam int PRE_W = $clog2(DIV);
    localparam int VAL_W = SEC_W + 7;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};

    localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [SEC_W-1:0] LIMIT    = SEC_W'(LIMIT_SEC);
    localparam logic [SEC_W-1:0] SEC_INIT = (COUNT_DOWN != 0) ? LIMIT : SEC_ZERO;

    localparam logic [6:0] HUND_ZERO = 7'd0;
    localparam logic [6:0] HUND_ONE  = 7'd1;
    localparam logic [6:0] HUND_MAX  = 7'd99;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PAUSED  = 3'd2;
    localparam logic [2:0] S_STOPPED = 3'd3;
    localparam logic [2:0] S_EXPIRED = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [PRE_W-1:0] presc_r;
    logic [PRE_W-1:0] presc_s;
    logic [SEC_W-1:0] sec_r;
    logic [SEC_W-1:0] sec_s;
    logic [6:0]       hund_r;
    logic [6:0]       hund_s;
    logic             tick_s;
    logic             running_r;
    logic             time_up_r;
    logic             tick_r;
    logic [VAL_W-1:0] step_val_s;

    // Advance {seconds, hundredths} by one hundredth in the configured direction.
    function automatic logic [VAL_W-1:0] step_value(input logic [SEC_W-1:0] s,
                                                    input logic [6:0]       h);
        logic [VAL_W-1:0] r;
        if (COUNT_DOWN != 0) begin
            if (h == HUND_ZERO) begin
                r = {s - SEC_ONE, HUND_MAX};
            end else begin
                r = {s, h - HUND_ONE};
            end
        end else begin
            if (h == HUND_MAX) begin
                r = {s + SEC_ONE, HUND_ZERO};
            end else begin
                r = {s, h + HUND_ONE};
            end
        end
        return r;
    endfunction

    // True when a freshly stepped value is the terminal value of the run.
    function automatic logic is_final(input logic [VAL_W-1:0] v);
        logic f;
        if (COUNT_DOWN != 0) begin
            f = (v == {SEC_ZERO, HUND_ZERO});
        end else begin
            f = (v == {LIMIT, HUND_ZERO});
        end
        return f;
    endfunction

    // Candidate value one hundredth on from the current one.
    always_comb begin
        step_val_s = step_value(sec_r, hund_r);
    end

    // Next-state, prescaler and value logic; priority start > stop > pause.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        sec_s   = sec_r;
        hund_s  = hund_r;
        tick_s  = 1'b0;
        if (start) begin
            presc_s = PRE_ZERO;
            sec_s   = SEC_INIT;
            hund_s  = HUND_ZERO;
            state_s = pause ? S_PAUSED : S_RUN;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sec_s  = SEC_ZERO;
                    hund_s = HUND_ZERO;
                end
                S_RUN: begin
                    if (stop) begin
                        state_s = S_STOPPED;
                    end else if (pause) begin
                        // Leave the prescaler untouched so the partial
                        // hundredth survives the pause.
                        state_s = S_PAUSED;
                    end else if (presc_r == PRE_MAX) begin
                        presc_s = PRE_ZERO;
                        {sec_s, hund_s} = step_val_s;
                        tick_s  = 1'b1;
                        // Expiry lands on the same edge as the final step.
                        state_s = is_final(step_val_s) ? S_EXPIRED : S_RUN;
                    end else begin
                        presc_s = presc_r + PRE_ONE;
                    end
                end
                S_PAUSED: begin
                    if (stop) begin
                        state_s = S_STOPPED;
                    end else if (!pause) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_PAUSED;
                    end
                end
                S_STOPPED, S_EXPIRED: begin
                    state_s = state_r;
                end
                default: begin
                    // Unreachable encodings recover to a clean idle.
                    state_s = S_IDLE;
                    presc_s = PRE_ZERO;
                    sec_s   = SEC_ZERO;
                    hund_s  = HUND_ZERO;
                end
            endcase
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            presc_r   <= PRE_ZERO;
            sec_r     <= SEC_ZERO;
            hund_r    <= HUND_ZERO;
            running_r <= 1'b0;
            time_up_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            sec_r     <= sec_s;
            hund_r    <= hund_s;
            running_r <= (state_s == S_RUN);
            time_up_r <= (state_s == S_EXPIRED);
            tick_r    <= tick_s;
        end
    end

    assign running        = running_r;
    assign time_up        = time_up_r;
    assign tick_hundredth = tick_r;
    assign seconds        = sec_r;
    assign hundredths     = hund_r;

endmodule

// File: tb/tb_game_timer.sv
// ----------------------------------------------------------------------------
// tb_game_timer
//   Two timer instances at CLK_FREQ_HZ=1000 (DIV=10): a count-up one with a
//   2 s limit and a count-down one with a 1 s limit. Stimulus pushes the
//   expected output values, keyed by clock-edge number, onto a scoreboard;
//   a negedge monitor pops and compares them when that edge has happened.
// ----------------------------------------------------------------------------
module tb_game_timer;

    logic       clk;
    logic       rst;
    logic       up_start, up_pause, up_stop;
    logic       up_running, up_time_up, up_tick;
    logic [5:0] up_sec;
    logic [6:0] up_hund;
    logic       dn_start, dn_pause, dn_stop;
    logic       dn_running, dn_time_up, dn_tick;
    logic [5:0] dn_sec;
    logic [6:0] dn_hund;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;   // number of rising clk edges so far

    int    sb_cyc[$];
    int    sb_sel[$];
    int    sb_exp[$];
    string sb_tag[$];

    game_timer #(.CLK_FREQ_HZ(1000), .LIMIT_SEC(2), .SEC_W(6), .COUNT_DOWN(0)) u_up (
        .clk(clk), .rst(rst), .start(up_start), .pause(up_pause), .stop(up_stop),
        .running(up_running), .time_up(up_time_up), .tick_hundredth(up_tick),
        .seconds(up_sec), .hundredths(up_hund)
    );

    game_timer #(.CLK_FREQ_HZ(1000), .LIMIT_SEC(1), .SEC_W(6), .COUNT_DOWN(1)) u_dn (
        .clk(clk), .rst(rst), .start(dn_start), .pause(dn_pause), .stop(dn_stop),
        .running(dn_running), .time_up(dn_time_up), .tick_hundredth(dn_tick),
        .seconds(dn_sec), .hundredths(dn_hund)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) e <= e + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // sel: 0..3 = up running/time_up/tick/value, 4..7 = same for down; value = sec*100+hund
    function automatic logic [31:0] observe(input int sel);
        logic [31:0] r;
        case (sel)
            0: r = {31'd0, up_running};
            1: r = {31'd0, up_time_up};
            2: r = {31'd0, up_tick};
            3: r = 32'(up_sec) * 32'd100 + 32'(up_hund);
            4: r = {31'd0, dn_running};
            5: r = {31'd0, dn_time_up};
            6: r = {31'd0, dn_tick};
            7: r = 32'(dn_sec) * 32'd100 + 32'(dn_hund);
            default: r = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    task automatic expect_at(input int c, input int sel, input int v, input string tag);
        sb_cyc.push_back(c);
        sb_sel.push_back(sel);
        sb_exp.push_back(v);
        sb_tag.push_back(tag);
    endtask

    // Scoreboard monitor: compare entries due at this edge, flag stale ones.
    always @(negedge clk) begin
        for (int i = sb_cyc.size() - 1; i >= 0; i--) begin
            if (sb_cyc[i] <= e) begin
                if (sb_cyc[i] == e)
                    check_val(sb_tag[i], observe(sb_sel[i]), sb_exp[i]);
                else
                    check_val({sb_tag[i], "_stale"}, 32'(sb_cyc[i]), 32'(e));
                sb_cyc.delete(i);
                sb_sel.delete(i);
                sb_exp.delete(i);
                sb_tag.delete(i);
            end
        end
    end

    // Called at a negedge; s_edge is the edge that samples the start pulse.
    task automatic drive_start(input int which, input logic with_stop, output int s_edge);
        s_edge = e + 1;
        if (which == 0) begin
            up_start = 1'b1; up_stop = with_stop;
        end else begin
            dn_start = 1'b1; dn_stop = with_stop;
        end
        @(negedge clk);
        up_start = 1'b0; up_stop = 1'b0;
        dn_start = 1'b0; dn_stop = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (e < t) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", e);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s2;
        rst = 1'b1;
        up_start = 1'b0; up_pause = 1'b0; up_stop = 1'b0;
        dn_start = 1'b0; dn_pause = 1'b0; dn_stop = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_running", {31'd0, up_running}, 32'd0);
        check_val("rst_time_up", {31'd0, up_time_up}, 32'd0);
        check_val("rst_tick",    {31'd0, up_tick}, 32'd0);
        check_val("rst_value",   observe(3), 32'd0);
        check_val("rst_dn_value", observe(7), 32'd0);
        rst = 1'b0;
        expect_at(e + 3, 0, 0, "idle_running");
        expect_at(e + 3, 3, 0, "idle_value");
        wait_until(e + 5);

        // 1: count-up to the 2 s limit
        drive_start(0, 1'b0, s);
        expect_at(s,        0, 1,   "t1_running_rise");
        expect_at(s,        3, 0,   "t1_initial_value");
        expect_at(s + 9,    3, 0,   "t1_before_first_tick");
        expect_at(s + 9,    2, 0,   "t1_no_tick_early");
        expect_at(s + 10,   3, 1,   "t1_first_step");
        expect_at(s + 10,   2, 1,   "t1_first_tick");
        expect_at(s + 11,   2, 0,   "t1_tick_one_cycle");
        expect_at(s + 1000, 3, 100, "t1_one_second");
        expect_at(s + 1999, 3, 199, "t1_pre_limit");
        expect_at(s + 1999, 0, 1,   "t1_pre_limit_running");
        expect_at(s + 2000, 3, 200, "t1_limit_value");
        expect_at(s + 2000, 1, 1,   "t1_time_up");
        expect_at(s + 2000, 0, 0,   "t1_running_drop");
        expect_at(s + 2000, 2, 1,   "t1_final_tick");
        expect_at(s + 2001, 2, 0,   "t1_no_tick_after");
        expect_at(s + 2500, 3, 200, "t1_held_value");
        expect_at(s + 2500, 1, 1,   "t1_held_time_up");
        wait_until(s + 2502);

        // 2: pause for 37 cycles at prescaler=4
        drive_start(0, 1'b0, s);
        wait_until(s + 14);
        up_pause = 1'b1;
        expect_at(s + 15, 0, 0, "t2_paused_running");
        expect_at(s + 30, 3, 1, "t2_frozen_value");
        expect_at(s + 30, 2, 0, "t2_no_tick_paused");
        wait_until(s + 51);
        up_pause = 1'b0;
        expect_at(s + 52,   0, 1,   "t2_resume_running");
        expect_at(s + 57,   3, 1,   "t2_before_resumed_tick");
        expect_at(s + 58,   3, 2,   "t2_resumed_step");
        expect_at(s + 58,   2, 1,   "t2_resumed_tick");
        expect_at(s + 1038, 3, 100, "t2_shift_38");
        wait_until(s + 1040);

        // 3: stop at 1.23, pause ignored, restart
        drive_start(0, 1'b0, s);
        wait_until(s + 1230);
        up_stop = 1'b1;
        @(negedge clk);
        up_stop = 1'b0;
        expect_at(s + 1231, 3, 123, "t3_stop_value");
        expect_at(s + 1231, 1, 0,   "t3_stop_time_up");
        expect_at(s + 1231, 0, 0,   "t3_stop_running");
        expect_at(s + 1260, 3, 123, "t3_hold_value");
        expect_at(s + 1290, 0, 0,   "t3_hold_running");
        for (int k = 0; k < 60; k++) begin
            up_pause = ~up_pause;
            @(negedge clk);
        end
        up_pause = 1'b0;
        wait_until(s + 1300);
        drive_start(0, 1'b0, s2);
        expect_at(s2,      3, 0, "t3_restart_value");
        expect_at(s2,      0, 1, "t3_restart_running");
        expect_at(s2 + 10, 3, 1, "t3_restart_step");

        // 5: start+stop together while running, then start with pause high
        wait_until(s2 + 500);
        drive_start(0, 1'b1, s);
        expect_at(s,      0, 1, "t5_startstop_running");
        expect_at(s,      3, 0, "t5_startstop_value");
        expect_at(s + 10, 3, 1, "t5_startstop_step");
        wait_until(s + 15);
        up_pause = 1'b1;
        drive_start(0, 1'b0, s);
        expect_at(s,      0, 0, "t5_startpause_running");
        expect_at(s,      3, 0, "t5_startpause_value");
        expect_at(s + 20, 3, 0, "t5_startpause_frozen");
        expect_at(s + 20, 2, 0, "t5_startpause_no_tick");
        wait_until(s + 20);
        up_pause = 1'b0;
        expect_at(s + 21, 0, 1, "t5_release_running");
        expect_at(s + 30, 3, 0, "t5_release_before_step");
        expect_at(s + 31, 3, 1, "t5_release_step");
        wait_until(s + 33);

        // 4: count-down from 1.00
        drive_start(1, 1'b0, s);
        expect_at(s,        7, 100, "t4_initial_value");
        expect_at(s,        4, 1,   "t4_running");
        expect_at(s + 9,    7, 100, "t4_before_first_step");
        expect_at(s + 10,   7, 99,  "t4_first_step");
        expect_at(s + 10,   6, 1,   "t4_first_tick");
        expect_at(s + 999,  7, 1,   "t4_pre_zero");
        expect_at(s + 1000, 7, 0,   "t4_zero_value");
        expect_at(s + 1000, 5, 1,   "t4_time_up");
        expect_at(s + 1000, 4, 0,   "t4_running_drop");
        expect_at(s + 1200, 7, 0,   "t4_no_wrap");
        expect_at(s + 1200, 5, 1,   "t4_held_time_up");
        wait_until(s + 1202);

        // 6: asynchronous reset mid-run at 0.57
        drive_start(0, 1'b0, s);
        expect_at(s + 570, 3, 57, "t6_value_before_rst");
        wait_until(s + 570);
        #2;
        rst = 1'b1;
        #1;
        s2 = e;
        check_val("t6_async_edge_count", 32'(e), 32'(s + 570));
        check_val("t6_async_running", {31'd0, up_running}, 32'd0);
        check_val("t6_async_time_up", {31'd0, up_time_up}, 32'd0);
        check_val("t6_async_tick",    {31'd0, up_tick}, 32'd0);
        check_val("t6_async_value",   observe(3), 32'd0);
        check_val("t6_async_dn_time_up", {31'd0, dn_time_up}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        up_pause = 1'b1;
        up_stop  = 1'b1;
        @(negedge clk);
        up_stop = 1'b0;
        expect_at(e + 2,  0, 0, "t6_idle_running");
        expect_at(e + 2,  3, 0, "t6_idle_value");
        expect_at(e + 15, 2, 0, "t6_idle_no_tick");
        expect_at(e + 15, 3, 0, "t6_idle_value_held");
        wait_until(e + 5);
        up_pause = 1'b0;
        wait_until(s2 + 30);

        check_val("sb_drain", 32'(sb_cyc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
